// File: rtl/hack_soc_pkg.sv
// Shared Hack SoC constants: ROM geometry and the rom_loader_responder state encoding.
package hack_soc_pkg;

  localparam int ROM_ADDRESS_WIDTH = 16;
  localparam int INSTRUCTION_WIDTH = 16;
  localparam int ROM_MAX_WORDS     = 32768;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_WRITE    = 3'd2;
  localparam logic [2:0] ST_ACK      = 3'd3;
  localparam logic [2:0] ST_WAIT_LOW = 3'd4;
  localparam logic [2:0] ST_RELEASE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ARMED    = ST_ARMED,
    WRITE    = ST_WRITE,
    ACK      = ST_ACK,
    WAIT_LOW = ST_WAIT_LOW,
    RELEASE  = ST_RELEASE
  } loader_state_t;

endpackage

// File: rtl/rom_loader_responder.sv
// SoC-side responder for the serial ROM loader: writes each strobed word to the next ROM address,
// acks it, and keeps the CPU in reset / the ROM bus owned for the duration of the load session.
module rom_loader_responder
  import hack_soc_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDRESS_WIDTH,
  parameter int MAX_WORDS  = ROM_MAX_WORDS,
  parameter int DATA_WIDTH = INSTRUCTION_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_loader_load,
  input  logic                  rom_loader_sck,
  input  logic [DATA_WIDTH-1:0] rom_loader_data,
  output logic                  rom_loader_ack,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic                  bus_owned,
  output logic                  cpu_hold_reset,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(MAX_WORDS);

  loader_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   words_reg, words_next;
  logic [DATA_WIDTH-1:0] checksum_reg, checksum_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  overflow_reg, overflow_next;
  logic                  bus_owned_reg, bus_owned_next;
  logic                  cpu_hold_reg, cpu_hold_next;
  logic                  load_lost_reg, load_lost_next;
  logic                  sck_prev_reg;
  logic                  sck_rise;

  assign sck_rise = rom_loader_sck & ~sck_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      words_reg     <= '0;
      checksum_reg  <= '0;
      data_reg      <= '0;
      overflow_reg  <= 1'b0;
      bus_owned_reg <= 1'b0;
      cpu_hold_reg  <= 1'b1;
      load_lost_reg <= 1'b0;
      sck_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      words_reg     <= words_next;
      checksum_reg  <= checksum_next;
      data_reg      <= data_next;
      overflow_reg  <= overflow_next;
      bus_owned_reg <= bus_owned_next;
      cpu_hold_reg  <= cpu_hold_next;
      load_lost_reg <= load_lost_next;
      sck_prev_reg  <= rom_loader_sck;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    words_next     = words_reg;
    checksum_next  = checksum_reg;
    data_next      = data_reg;
    overflow_next  = overflow_reg;
    bus_owned_next = bus_owned_reg;
    cpu_hold_next  = cpu_hold_reg;
    load_lost_next = load_lost_reg;

    case (state_reg)
      IDLE: begin
        if (rom_loader_load) begin
          state_next     = ARMED;
          addr_next      = '0;
          words_next     = '0;
          checksum_next  = '0;
          overflow_next  = 1'b0;
          bus_owned_next = 1'b1;
          cpu_hold_next  = 1'b1;
        end
      end
      ARMED: begin
        // Load dropping wins over a simultaneous strobe; that word is discarded.
        if (!rom_loader_load) begin
          state_next     = RELEASE;
          bus_owned_next = 1'b0;
        end else if (sck_rise) begin
          data_next = rom_loader_data;
          if (words_reg < MAX_COUNT) begin
            state_next     = WRITE;
            load_lost_next = 1'b0;
          end else begin
            overflow_next = 1'b1;
            state_next    = ACK;
          end
        end
      end
      WRITE: begin
        // The QSPI write is never aborted; remember a dropped load and release once it completes.
        if (!rom_loader_load) load_lost_next = 1'b1;
        if (mem_ack) begin
          words_next    = words_reg + 1'b1;
          checksum_next = checksum_reg + data_reg;
          if ((words_reg + 1'b1) < MAX_COUNT) addr_next = addr_reg + 1'b1;
          if (load_lost_reg || !rom_loader_load) begin
            state_next     = RELEASE;
            bus_owned_next = 1'b0;
          end else begin
            state_next = ACK;
          end
        end
      end
      ACK: begin
        if (!rom_loader_load) begin
          state_next     = RELEASE;
          bus_owned_next = 1'b0;
        end else begin
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!rom_loader_load) begin
          state_next     = RELEASE;
          bus_owned_next = 1'b0;
        end else if (!rom_loader_sck) begin
          state_next = ARMED;
        end
      end
      RELEASE: begin
        // Bus handed back one cycle before the CPU leaves reset.
        cpu_hold_next = 1'b0;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rom_loader_ack = (state_reg == ACK);
  assign mem_req        = (state_reg == WRITE);
  assign mem_addr       = addr_reg;
  assign mem_wdata      = data_reg;
  assign bus_owned      = bus_owned_reg;
  assign cpu_hold_reset = cpu_hold_reg;
  assign words_loaded   = words_reg;
  assign checksum       = checksum_reg;
  assign overflow       = overflow_reg;

endmodule
